// File: rtl/core_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: FSM states,
// major opcodes, ALU operation classes and datapath mux selects.
package core_ctrl_pkg;

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC_R = 4'd6;
    localparam logic [3:0] S_EXEC_I = 4'd7;
    localparam logic [3:0] S_ALUWB  = 4'd8;
    localparam logic [3:0] S_BRANCH = 4'd9;
    localparam logic [3:0] S_HALT   = 4'd10;

    typedef enum logic [3:0] {
        FETCH  = S_FETCH,
        DECODE = S_DECODE,
        MEMADR = S_MEMADR,
        MEMRD  = S_MEMRD,
        MEMWB  = S_MEMWB,
        MEMWR  = S_MEMWR,
        EXEC_R = S_EXEC_R,
        EXEC_I = S_EXEC_I,
        ALUWB  = S_ALUWB,
        BRANCH = S_BRANCH,
        HALT   = S_HALT
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_RS1   = 2'b01;
    localparam logic [1:0] SRCA_OLDPC = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    // States that hold on the memory port and are covered by the wait timeout.
    function automatic logic is_wait_state(input state_e s);
        return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle controller (master) and the datapath (slave).
interface multicycle_ctrl_if #(parameter int CNT_W = 32);

    logic [6:0]       opcode;
    logic             zero;
    logic             mem_ready;
    logic             pc_write;
    logic             pc_write_cond;
    logic             ir_write;
    logic             mem_read;
    logic             mem_write;
    logic             i_or_d;
    logic             reg_write;
    logic             mem_to_reg;
    logic [1:0]       alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic             pc_src;
    logic             fault;
    logic [CNT_W-1:0] retired;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, pc_write_cond, ir_write, mem_read, mem_write, i_or_d,
               reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src,
               fault, retired
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, pc_write_cond, ir_write, mem_read, mem_write, i_or_d,
               reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src,
               fault, retired
    );

endinterface

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core, with memory-wait timeout,
// sticky fault flag and retired-instruction counter.
module multicycle_ctrl
    import core_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 32
) (
    input  logic                clk,
    input  logic                reset,
    multicycle_ctrl_if.master   bus
);

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_e           state_q, state_d;
    logic             fault_q, fault_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic [7:0]       wait_q, wait_d;
    logic             retire_s;
    logic             timeout_s;

    // State, fault, retired and wait-counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= FETCH;
            fault_q   <= 1'b0;
            retired_q <= '0;
            wait_q    <= 8'd0;
        end else begin
            state_q   <= state_d;
            fault_q   <= fault_d;
            retired_q <= retired_d;
            wait_q    <= wait_d;
        end
    end

    // Next-state logic; the timeout fires on the last allowed wait cycle only if memory is still busy.
    always_comb begin
        state_d   = state_q;
        fault_d   = fault_q;
        retire_s  = 1'b0;
        timeout_s = is_wait_state(state_q) && !bus.mem_ready && (wait_q == WAIT_LAST);
        case (state_q)
            FETCH, MEMRD, MEMWR: begin
                if (bus.mem_ready) begin
                    if (state_q == FETCH) begin
                        state_d = DECODE;
                    end else if (state_q == MEMRD) begin
                        state_d = MEMWB;
                    end else begin
                        state_d  = FETCH;
                        retire_s = 1'b1;
                    end
                end else if (timeout_s) begin
                    state_d = HALT;
                    fault_d = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            DECODE: begin
                case (bus.opcode)
                    OP_LOAD, OP_STORE: state_d = MEMADR;
                    OP_RTYPE:          state_d = EXEC_R;
                    OP_ITYPE:          state_d = EXEC_I;
                    OP_BRANCH:         state_d = BRANCH;
                    default: begin
                        state_d = HALT;
                        fault_d = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                if (bus.opcode == OP_STORE) begin
                    state_d = MEMWR;
                end else begin
                    state_d = MEMRD;
                end
            end
            EXEC_R, EXEC_I: state_d = ALUWB;
            MEMWB, ALUWB, BRANCH: begin
                state_d  = FETCH;
                retire_s = 1'b1;
            end
            HALT: state_d = HALT;
            default: begin
                state_d = HALT;
                fault_d = 1'b1;
            end
        endcase
        retired_d = retire_s ? (retired_q + CNT_W'(1)) : retired_q;
        wait_d    = (is_wait_state(state_q) && (state_d == state_q)) ? (wait_q + 8'd1) : 8'd0;
    end

    // Control outputs decoded from the current state; enables are forced low while reset is held.
    always_comb begin
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.ir_write      = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.i_or_d        = 1'b0;
        bus.reg_write     = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.alu_src_a     = SRCA_PC;
        bus.alu_src_b     = SRCB_RS2;
        bus.alu_op        = ALUOP_ADD;
        bus.pc_src        = 1'b0;
        if (reset) begin
            bus.alu_src_b = SRCB_FOUR;
        end else begin
            case (state_q)
                FETCH: begin
                    bus.mem_read  = 1'b1;
                    bus.ir_write  = bus.mem_ready;
                    bus.pc_write  = bus.mem_ready;
                    bus.alu_src_b = SRCB_FOUR;
                end
                DECODE: begin
                    bus.alu_src_a = SRCA_OLDPC;
                    bus.alu_src_b = SRCB_IMM;
                end
                MEMADR, EXEC_I: begin
                    bus.alu_src_a = SRCA_RS1;
                    bus.alu_src_b = SRCB_IMM;
                    bus.alu_op    = (state_q == EXEC_I) ? ALUOP_FUNC : ALUOP_ADD;
                end
                MEMRD: begin
                    bus.mem_read = 1'b1;
                    bus.i_or_d   = 1'b1;
                end
                MEMWB: begin
                    bus.reg_write  = 1'b1;
                    bus.mem_to_reg = 1'b1;
                end
                MEMWR: begin
                    bus.mem_write = 1'b1;
                    bus.i_or_d    = 1'b1;
                end
                EXEC_R: begin
                    bus.alu_src_a = SRCA_RS1;
                    bus.alu_op    = ALUOP_FUNC;
                end
                ALUWB: bus.reg_write = 1'b1;
                BRANCH: begin
                    bus.alu_src_a     = SRCA_RS1;
                    bus.alu_op        = ALUOP_SUB;
                    bus.pc_write_cond = 1'b1;
                    bus.pc_src        = 1'b1;
                end
                default: bus.pc_src = 1'b0;
            endcase
        end
    end

    assign bus.fault   = fault_q;
    assign bus.retired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: a cycle table of instruction flows
// plus hand sequences for timeout, illegal opcode and mid-instruction reset.
module tb_multicycle_ctrl;

    logic clk;
    logic reset;

    multicycle_ctrl_if #(.CNT_W(32)) bus ();

    multicycle_ctrl #(.MAX_WAIT(15), .CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [6:0]  op;
        logic        z;
        logic        rdy;
        logic [14:0] ctl;
        logic        flt;
        logic [31:0] ret;
    } vec_t;

    typedef struct {
        string       name;
        logic [14:0] ctl;
        logic        flt;
        logic [31:0] ret;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    localparam logic [6:0] LD  = 7'b0000011;
    localparam logic [6:0] ST  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] BAD = 7'b1111111;

    logic [14:0] c_rst, c_fw, c_fr, c_dec, c_ma, c_mrd, c_mwb, c_mwr, c_er, c_ei, c_awb, c_br, c_halt;

    // Packs control outputs as {pc_write, pc_write_cond, ir_write, mem_read, mem_write, i_or_d, reg_write, mem_to_reg, src_a, src_b, alu_op, pc_src}.
    function automatic logic [14:0] mk(input logic pcw, input logic pcwc, input logic irw,
                                       input logic mrd, input logic mwr, input logic iod,
                                       input logic rw, input logic m2r, input logic [1:0] a,
                                       input logic [1:0] b, input logic [1:0] op, input logic ps);
        return {pcw, pcwc, irw, mrd, mwr, iod, rw, m2r, a, b, op, ps};
    endfunction

    function automatic logic [14:0] act_ctl();
        return mk(bus.pc_write, bus.pc_write_cond, bus.ir_write, bus.mem_read, bus.mem_write,
                  bus.i_or_d, bus.reg_write, bus.mem_to_reg, bus.alu_src_a, bus.alu_src_b,
                  bus.alu_op, bus.pc_src);
    endfunction

    task automatic row(input logic rst, input logic [6:0] op, input logic z, input logic rdy,
                       input logic [14:0] ctl, input logic flt, input logic [31:0] ret);
        vec_t v;
        v.rst = rst; v.op = op; v.z = z; v.rdy = rdy; v.ctl = ctl; v.flt = flt; v.ret = ret;
        tbl.push_back(v);
    endtask

    // Pushes the expectation, lets combinational outputs settle, then pops and compares.
    task automatic expect_now(input string name, input logic [14:0] ctl, input logic flt,
                              input logic [31:0] ret);
        exp_t e;
        e.name = name; e.ctl = ctl; e.flt = flt; e.ret = ret;
        sb.push_back(e);
        #1;
        e = sb.pop_front();
        n_vec++;
        if (act_ctl() !== e.ctl || bus.fault !== e.flt || bus.retired !== e.ret) begin
            n_bad++;
            $display("FAIL %s: got ctl=%b fault=%b retired=%0d, want ctl=%b fault=%b retired=%0d",
                     e.name, act_ctl(), bus.fault, bus.retired, e.ctl, e.flt, e.ret);
        end
    endtask

    task automatic step(input string name, input logic rst, input logic [6:0] op, input logic z,
                        input logic rdy, input logic [14:0] ctl, input logic flt,
                        input logic [31:0] ret);
        @(negedge clk);
        reset         = rst;
        bus.opcode    = op;
        bus.zero      = z;
        bus.mem_ready = rdy;
        expect_now(name, ctl, flt, ret);
    endtask

    initial begin
        reset         = 1'b1;
        bus.opcode    = 7'd0;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;

        c_rst  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0);
        c_fw   = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0);
        c_fr   = mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0);
        c_dec  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b10, 2'b00, 1'b0);
        c_ma   = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 2'b00, 1'b0);
        c_mrd  = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
        c_mwb  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0);
        c_mwr  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
        c_er   = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b10, 1'b0);
        c_ei   = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 2'b10, 1'b0);
        c_awb  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
        c_br   = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b01, 1'b1);
        c_halt = 15'd0;

        // One row per cycle: reset, R-type, I-type, load with 3 waits, store with a fetch wait, two branches.
        row(1'b1, RT, 1'b0, 1'b1, c_rst, 1'b0, 32'd0);
        row(1'b0, RT, 1'b0, 1'b1, c_fr,  1'b0, 32'd0);
        row(1'b0, RT, 1'b0, 1'b1, c_dec, 1'b0, 32'd0);
        row(1'b0, RT, 1'b0, 1'b1, c_er,  1'b0, 32'd0);
        row(1'b0, RT, 1'b0, 1'b1, c_awb, 1'b0, 32'd0);
        row(1'b0, IT, 1'b0, 1'b1, c_fr,  1'b0, 32'd1);
        row(1'b0, IT, 1'b0, 1'b1, c_dec, 1'b0, 32'd1);
        row(1'b0, IT, 1'b0, 1'b1, c_ei,  1'b0, 32'd1);
        row(1'b0, IT, 1'b0, 1'b1, c_awb, 1'b0, 32'd1);
        row(1'b0, LD, 1'b0, 1'b1, c_fr,  1'b0, 32'd2);
        row(1'b0, LD, 1'b0, 1'b1, c_dec, 1'b0, 32'd2);
        row(1'b0, LD, 1'b0, 1'b1, c_ma,  1'b0, 32'd2);
        row(1'b0, LD, 1'b0, 1'b0, c_mrd, 1'b0, 32'd2);
        row(1'b0, LD, 1'b0, 1'b0, c_mrd, 1'b0, 32'd2);
        row(1'b0, LD, 1'b0, 1'b0, c_mrd, 1'b0, 32'd2);
        row(1'b0, LD, 1'b0, 1'b1, c_mrd, 1'b0, 32'd2);
        row(1'b0, LD, 1'b0, 1'b0, c_mwb, 1'b0, 32'd2);
        row(1'b0, ST, 1'b0, 1'b0, c_fw,  1'b0, 32'd3);
        row(1'b0, ST, 1'b0, 1'b1, c_fr,  1'b0, 32'd3);
        row(1'b0, ST, 1'b0, 1'b1, c_dec, 1'b0, 32'd3);
        row(1'b0, ST, 1'b0, 1'b1, c_ma,  1'b0, 32'd3);
        row(1'b0, ST, 1'b0, 1'b1, c_mwr, 1'b0, 32'd3);
        row(1'b0, BR, 1'b1, 1'b1, c_fr,  1'b0, 32'd4);
        row(1'b0, BR, 1'b1, 1'b1, c_dec, 1'b0, 32'd4);
        row(1'b0, BR, 1'b1, 1'b1, c_br,  1'b0, 32'd4);
        row(1'b0, BR, 1'b0, 1'b1, c_fr,  1'b0, 32'd5);
        row(1'b0, BR, 1'b0, 1'b1, c_dec, 1'b0, 32'd5);
        row(1'b0, BR, 1'b0, 1'b1, c_br,  1'b0, 32'd5);

        foreach (tbl[i]) begin
            step($sformatf("vec%0d", i), tbl[i].rst, tbl[i].op, tbl[i].z, tbl[i].rdy,
                 tbl[i].ctl, tbl[i].flt, tbl[i].ret);
        end

        // Memory answers on the 15th fetch cycle, exactly at the timeout limit: no fault.
        for (int i = 0; i < 14; i++) begin
            step($sformatf("edge_wait%0d", i), 1'b0, RT, 1'b0, 1'b0, c_fw, 1'b0, 32'd6);
        end
        step("edge_ready", 1'b0, RT, 1'b0, 1'b1, c_fr,  1'b0, 32'd6);
        step("edge_dec",   1'b0, RT, 1'b0, 1'b0, c_dec, 1'b0, 32'd6);
        step("edge_exec",  1'b0, RT, 1'b0, 1'b0, c_er,  1'b0, 32'd6);
        step("edge_wb",    1'b0, RT, 1'b0, 1'b0, c_awb, 1'b0, 32'd6);
        step("edge_next",  1'b0, RT, 1'b0, 1'b0, c_fw,  1'b0, 32'd7);

        // Reset asserted mid-cycle while in MEMWB aborts the load.
        step("ab_rst",  1'b1, LD, 1'b0, 1'b1, c_rst, 1'b0, 32'd0);
        step("ab_f",    1'b0, LD, 1'b0, 1'b1, c_fr,  1'b0, 32'd0);
        step("ab_d",    1'b0, LD, 1'b0, 1'b1, c_dec, 1'b0, 32'd0);
        step("ab_ma",   1'b0, LD, 1'b0, 1'b1, c_ma,  1'b0, 32'd0);
        step("ab_rd",   1'b0, LD, 1'b0, 1'b1, c_mrd, 1'b0, 32'd0);
        step("ab_wb",   1'b0, LD, 1'b0, 1'b1, c_mwb, 1'b0, 32'd0);
        #1;
        reset = 1'b1;
        expect_now("ab_async", c_rst, 1'b0, 32'd0);
        @(posedge clk);
        #1;
        expect_now("ab_held", c_rst, 1'b0, 32'd0);

        // Memory never answers in FETCH: HALT with fault after 15 wait cycles.
        for (int i = 0; i < 15; i++) begin
            step($sformatf("to_wait%0d", i), 1'b0, RT, 1'b0, 1'b0, c_fw, 1'b0, 32'd0);
        end
        step("to_halt",  1'b0, RT, 1'b0, 1'b1, c_halt, 1'b1, 32'd0);
        step("to_stay",  1'b0, RT, 1'b0, 1'b1, c_halt, 1'b1, 32'd0);

        // Illegal opcode: fault and HALT, enables stay low for 20 cycles.
        step("il_rst", 1'b1, BAD, 1'b0, 1'b1, c_rst, 1'b0, 32'd0);
        step("il_f",   1'b0, BAD, 1'b0, 1'b1, c_fr,  1'b0, 32'd0);
        step("il_d",   1'b0, BAD, 1'b0, 1'b1, c_dec, 1'b0, 32'd0);
        for (int i = 0; i < 20; i++) begin
            step($sformatf("il_halt%0d", i), 1'b0, BAD, 1'($urandom_range(1)), 1'(i % 2),
                 c_halt, 1'b1, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
